// File: rtl/alu_16bit_icg.sv
// alu_16bit_icg
//   Signed 16-bit ALU execution unit with an integrated clock-gating cell.
//   Single-cycle add/sub/compare/logic/shift/rotate; 16-iteration
//   sequential multiply (shift-add) and divide (restoring) on magnitudes,
//   with the sign applied when the last iteration completes.
//   Every state flop runs on the gated clock, so nothing toggles while en=0.
//
// Ports
//   clk     system clock
//   rst     asynchronous active-low reset
//   en      clock enable into the ICG (1 = gated clock runs)
//   start   issue strobe, sampled on gated-clock rising edge
//   op      4-bit opcode, sampled with start
//   A, B    signed operands (B[3:0] = shift/rotate amount)
//   Z_low   result low half (registered)
//   Z_high  result high half (registered)
//   valid   one-cycle result-ready pulse (registered)
module alu_16bit_icg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Z_low,
  output logic [15:0] Z_high,
  output logic        valid
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
    OP_CMP  = 4'h4, OP_NAND = 4'h5, OP_AND = 4'h6, OP_NOR = 4'h7,
    OP_OR   = 4'h8, OP_XOR = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
    OP_ROL  = 4'hC, OP_ROR = 4'hD
  } op_e;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  // ---------------------------------------------------------------------------
  // Clock gating: en is captured while clk is low so it is stable across the
  // high phase, which keeps gclk free of glitches.
  // ---------------------------------------------------------------------------
  logic en_lat;
  logic gclk;

  // NOTE: this latch is the intended ICG element, not an accidental inference;
  // it is the only level-sensitive storage in the block.
  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign gclk = clk & en_lat;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,    state_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [31:0] acc_q,      acc_d;     // MUL: {partial, multiplier}; DIV: {rem, quotient}
  logic [15:0] opnd_q,     opnd_d;    // MUL: multiplicand mag; DIV: divisor mag
  logic        is_div_q,   is_div_d;
  logic        neg_res_q,  neg_res_d; // sign of product / quotient
  logic        neg_rem_q,  neg_rem_d; // sign of remainder (sign of dividend)
  logic [15:0] z_low_q,    z_low_d;
  logic [15:0] z_high_q,   z_high_d;
  logic        valid_q,    valid_d;

  assign Z_low  = z_low_q;
  assign Z_high = z_high_q;
  assign valid  = valid_q;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  op_e         op_in;
  logic [15:0] a_mag, b_mag;
  logic [31:0] a_sext, b_sext;
  logic [31:0] rot_l, rot_r;
  logic [16:0] mul_sum;
  logic [31:0] mul_next;
  logic [16:0] div_shift;
  logic        div_fit;
  logic [15:0] div_rem;
  logic [31:0] div_next;
  logic [31:0] iter_next;

  assign op_in  = op_e'(op);
  // -(-32768) wraps to 16'h8000, which is the correct unsigned magnitude.
  assign a_mag  = A[15] ? 16'd0 - A : A;
  assign b_mag  = B[15] ? 16'd0 - B : B;
  assign a_sext = {{16{A[15]}}, A};
  assign b_sext = {{16{B[15]}}, B};
  assign rot_l  = {A, A} << B[3:0];
  assign rot_r  = {A, A} >> B[3:0];

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right (carry in).
  assign mul_sum  = {1'b0, acc_q[31:16]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[15:1]} : {1'b0, acc_q[31:1]};

  // Restoring step: bring in next dividend bit, subtract divisor if it fits.
  assign div_shift = {acc_q[31:16], acc_q[15]};
  assign div_fit   = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_fit ? 16'(div_shift - {1'b0, opnd_q}) : div_shift[15:0];
  assign div_next  = {div_rem, acc_q[14:0], div_fit};

  assign iter_next = is_div_q ? div_next : mul_next;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    z_low_d   = z_low_q;
    z_high_d  = z_high_q;
    valid_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          valid_d  = 1'b1;
          z_high_d = 16'h0000;
          case (op_in)
            OP_ADD:  {z_high_d, z_low_d} = a_sext + b_sext;
            OP_SUB:  {z_high_d, z_low_d} = a_sext - b_sext;
            OP_MUL: begin
              valid_d   = 1'b0;
              z_high_d  = z_high_q;
              acc_d     = {16'h0000, b_mag};
              opnd_d    = a_mag;
              is_div_d  = 1'b0;
              neg_res_d = A[15] ^ B[15];
              neg_rem_d = 1'b0;
              cnt_d     = 4'd0;
              state_d   = ST_BUSY;
            end
            OP_DIV: begin
              if (B == 16'h0000) begin
                z_low_d  = 16'hFFFF;
                z_high_d = A;
              end else begin
                valid_d   = 1'b0;
                z_high_d  = z_high_q;
                acc_d     = {16'h0000, a_mag};
                opnd_d    = b_mag;
                is_div_d  = 1'b1;
                neg_res_d = A[15] ^ B[15];
                neg_rem_d = A[15];
                cnt_d     = 4'd0;
                state_d   = ST_BUSY;
              end
            end
            OP_CMP:  z_low_d = {13'd0, $signed(A) > $signed(B), A == B,
                                $signed(A) < $signed(B)};
            OP_NAND: z_low_d = ~(A & B);
            OP_AND:  z_low_d = A & B;
            OP_NOR:  z_low_d = ~(A | B);
            OP_OR:   z_low_d = A | B;
            OP_XOR:  z_low_d = A ^ B;
            OP_SHL:  z_low_d = A << B[3:0];
            OP_SHR:  z_low_d = A >> B[3:0];
            OP_ROL:  z_low_d = rot_l[31:16];
            OP_ROR:  z_low_d = rot_r[15:0];
            default: z_low_d = 16'h0000;
          endcase
        end
      end

      ST_BUSY: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          valid_d = 1'b1;
          if (is_div_q) begin
            z_low_d  = neg_res_q ? 16'd0 - iter_next[15:0]  : iter_next[15:0];
            z_high_d = neg_rem_q ? 16'd0 - iter_next[31:16] : iter_next[31:16];
          end else begin
            {z_high_d, z_low_d} = neg_res_q ? 32'd0 - iter_next : iter_next;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers (all on gclk; reset is asynchronous and works while gated)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge.
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      acc_q     <= 32'd0;
      opnd_q    <= 16'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      z_low_q   <= 16'd0;
      z_high_q  <= 16'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      z_low_q   <= z_low_d;
      z_high_q  <= z_high_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_16bit_icg.sv
// tb_alu_16bit_icg
//   Directed-vector bench for alu_16bit_icg. Inputs change and outputs are
//   sampled on the falling clock edge; expected values are hand-computed.
module tb_alu_16bit_icg;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [3:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Z_low;
  logic [15:0] Z_high;
  logic        valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_16bit_icg dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .Z_low  (Z_low),
    .Z_high (Z_high),
    .valid  (valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle op: result and valid after the sampling edge, valid drops next.
  task automatic run_single(input string tag, input logic [3:0] o,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    check({tag, " z"}, {Z_high, Z_low}, exp);
    check({tag, " valid"}, 32'(valid), 32'd1);
    @(negedge clk);
    check({tag, " valid drop"}, 32'(valid), 32'd0);
  endtask

  // MUL/DIV: start is held (with a different op) for two busy cycles to show
  // it is ignored; an optional en=0 window stretches the latency.
  task automatic run_multi(input string tag, input logic [3:0] o,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input int stall_len);
    int cycles;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    op = 4'h0; A = 16'h1234; B = 16'h0000;
    cycles = 0;
    while (cycles < 80) begin
      @(negedge clk);
      cycles++;
      if (valid) break;
      if (cycles == 2) start = 1'b0;
      if (stall_len > 0 && cycles == 5) en = 1'b0;
      if (stall_len > 0 && cycles == 5 + stall_len) en = 1'b1;
    end
    start = 1'b0;
    en    = 1'b1;
    check({tag, " latency"}, 32'(cycles), 32'(16 + stall_len));
    check({tag, " z"}, {Z_high, Z_low}, exp);
    @(negedge clk);
    check({tag, " valid drop"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int saw_valid;
    rst = 1'b0; en = 1'b1; start = 1'b0; op = 4'h0; A = 16'h0; B = 16'h0;
    #45;
    check("reset z", {Z_high, Z_low}, 32'h0000_0000);
    check("reset valid", 32'(valid), 32'd0);
    #5 rst = 1'b1;

    // Add / subtract
    run_single("add 100+25",      4'h0, 16'd100,  16'd25,   32'h0000_007D);
    run_single("add 32767+1",     4'h0, 16'h7FFF, 16'h0001, 32'h0000_8000);
    run_single("sub -32768-1",    4'h1, 16'h8000, 16'h0001, 32'hFFFF_7FFF);
    run_single("sub -250-(-50)",  4'h1, 16'hFF06, 16'hFFCE, 32'hFFFF_FF38);

    // Multiply (first one stalled for 10 gated cycles)
    run_multi("mul 150x120 stall", 4'h2, 16'd150,  16'd120,  32'h0000_4650, 10);
    run_multi("mul -150x120",      4'h2, 16'hFF6A, 16'd120,  32'hFFFF_B9B0, 0);
    run_multi("mul -15000x-12000", 4'h2, 16'hC568, 16'hD120, 32'h0ABA_9500, 0);

    // Divide: {Z_high=remainder, Z_low=quotient}
    run_multi("div 100/3",     4'h3, 16'd100,  16'd3,    32'h0001_0021, 0);
    run_multi("div 100/-3",    4'h3, 16'd100,  16'hFFFD, 32'h0001_FFDF, 0);
    run_multi("div -100/-3",   4'h3, 16'hFF9C, 16'hFFFD, 32'hFFFF_0021, 0);
    run_single("div 15/0",     4'h3, 16'd15,   16'd0,    32'h000F_FFFF);

    // Compare
    run_single("cmp gt", 4'h4, 16'd12345, 16'hD8F0, 32'h0000_0004);
    run_single("cmp eq", 4'h4, 16'd500,   16'd500,  32'h0000_0002);
    run_single("cmp lt", 4'h4, 16'hCFC7,  16'd10000, 32'h0000_0001);

    // Logic, shifts, reserved opcodes
    run_single("nand", 4'h5, 16'h0F0F, 16'h0F0F, 32'h0000_F0F0);
    run_single("and",  4'h6, 16'h0F0F, 16'h0F0F, 32'h0000_0F0F);
    run_single("nor",  4'h7, 16'h0F0F, 16'h0F0F, 32'h0000_F0F0);
    run_single("or",   4'h8, 16'h0F0F, 16'h0F0F, 32'h0000_0F0F);
    run_single("xor",  4'h9, 16'h0F0F, 16'h0F0F, 32'h0000_0000);
    run_single("shl 8",  4'hA, 16'h0F0F, 16'd8,  32'h0000_0F00);
    run_single("shr 8",  4'hB, 16'h0F0F, 16'd8,  32'h0000_000F);
    run_single("shr 15", 4'hB, 16'h0F0F, 16'd15, 32'h0000_0000);
    run_single("op e",   4'hE, 16'h0F0F, 16'h0F0F, 32'h0000_0000);
    run_single("op f",   4'hF, 16'hFFFF, 16'hFFFF, 32'h0000_0000);

    // Rotates
    run_single("rol 0",  4'hC, 16'h0F0F, 16'd0,  32'h0000_0F0F);
    run_single("rol 1",  4'hC, 16'h0F0F, 16'd1,  32'h0000_1E1E);
    run_single("rol 4",  4'hC, 16'h0F0F, 16'd4,  32'h0000_F0F0);
    run_single("rol 8",  4'hC, 16'h0F0F, 16'd8,  32'h0000_0F0F);
    run_single("rol 15", 4'hC, 16'h0F0F, 16'd15, 32'h0000_8787);
    run_single("ror 0",  4'hD, 16'h0F0F, 16'd0,  32'h0000_0F0F);
    run_single("ror 1",  4'hD, 16'h0F0F, 16'd1,  32'h0000_8787);
    run_single("ror 4",  4'hD, 16'h0F0F, 16'd4,  32'h0000_F0F0);
    run_single("ror 8",  4'hD, 16'h0F0F, 16'd8,  32'h0000_0F0F);
    run_single("ror 15", 4'hD, 16'h0F0F, 16'd15, 32'h0000_1E1E);

    // Leave a nonzero result, then show start is not seen while gated.
    run_single("add 1+2", 4'h0, 16'd1, 16'd2, 32'h0000_0003);
    @(negedge clk);
    en = 1'b0; start = 1'b1; op = 4'h0; A = 16'd7; B = 16'd7;
    @(negedge clk);
    @(negedge clk);
    check("gated start valid", 32'(valid), 32'd0);
    check("gated start z", {Z_high, Z_low}, 32'h0000_0003);
    start = 1'b0; en = 1'b1;

    // Reset in the middle of a multiply: outputs clear, no valid afterwards.
    @(negedge clk);
    start = 1'b1; op = 4'h2; A = 16'd150; B = 16'd120;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid-mul reset z", {Z_high, Z_low}, 32'h0000_0000);
    check("mid-mul reset valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid) saw_valid = 1;
    end
    check("no valid after abort", 32'(saw_valid), 32'd0);
    check("z after abort", {Z_high, Z_low}, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_16bit_icg.md
# alu_16bit_icg

Signed 16-bit ALU with an integrated clock-gating cell: 14 operations, including single-cycle add/sub/compare/logic/shift/rotate and 16-iteration sequential multiply and divide. All state registers run on an internally gated clock controlled by `en`, so the block draws no dynamic clock power while idle or stalled. Results are presented as a 32-bit pair (`Z_high`, `Z_low`) with a one-cycle `valid` pulse. It sits as an execution unit beside a controller that issues `start`/`op` and consumes results on `valid`.

## Interface
- No parameters; data width is fixed at 16 bits.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  clock enable into the integrated clock-gating (ICG) cell; 1 = gated clock runs, 0 = gated clock stopped and all state frozen.
- `start`  in  1  issue strobe; sampled on the gated-clock rising edge.
- `op`  in  4  opcode; sampled with `start`.
- `A`  in  16  signed operand.
- `B`  in  16  signed operand; `B[3:0]` is the shift/rotate amount.
- `Z_low`  out  16  result low half, registered.
- `Z_high`  out  16  result high half, registered.
- `valid`  out  1  result-ready pulse, registered.

## Operation
- **ICG cell:** a latch is transparent while `clk`=0 and captures `en`; `gclk = clk & en_lat`. The gated clock is glitch-free, and an `en` change during `clk`-high takes effect from the next cycle. Every flop is clocked by `gclk`.
- **Opcodes.** Unless stated otherwise, `Z_high` = 0.
  - 0000 ADD: {Z_high,Z_low} = sext32(A) + sext32(B).
  - 0001 SUB: {Z_high,Z_low} = sext32(A) − sext32(B).
  - 0010 MUL: {Z_high,Z_low} = signed 32-bit A×B. Computed as magnitude shift-add over 16 iterations, with sign fixed at the end.
  - 0011 DIV: signed division truncating toward zero. Z_low = quotient; Z_high = remainder, which takes the sign of A. Computed as magnitude restoring division over 16 iterations.
  - DIV with B = 0: Z_low = 16'hFFFF, Z_high = A. Completes with single-cycle timing.
  - 0100 CMP (signed): Z_low = {13'b0, A>B, A==B, A<B}.
  - 0101 NAND, 0110 AND, 0111 NOR, 1000 OR, 1001 XOR: bitwise A with B into Z_low.
  - 1010 SHL, 1011 SHR: logical shift of A by B[3:0], zero-filled.
  - 1100 ROL, 1101 ROR: rotate A by B[3:0].
  - 1110, 1111: Z_low = Z_high = 0, with normal valid pulse.
- **FSM states:**
  - IDLE: on `start`, single-cycle ops and DIV-by-zero write results and `valid`, then remain in IDLE. MUL and DIV latch operand magnitudes and signs, clear the counter, and go to BUSY.
  - BUSY: one iteration per gclk; after the 16th iteration, write the signed result, pulse `valid`, and return to IDLE.
- `start` while BUSY is ignored; `op`, `A` and `B` are don't-care during BUSY.
- `Z_low` and `Z_high` hold their last result until the next result is written.

## Timing
- **Reset (`rst`=0):** asynchronous, regardless of `en`. `Z_low`=0, `Z_high`=0, `valid`=0, FSM=IDLE, counter=0. Reset mid-MUL/DIV aborts the operation with no `valid`.
- **Single-cycle ops:** gclk edge k samples `start`=1. Results and `valid`=1 appear after edge k. `valid` returns to 0 after edge k+1 unless a new `start` is sampled at edge k+1.
- **MUL/DIV:** edge k captures the operands. Iterations run at edges k+1..k+16. Results and `valid`=1 appear after edge k+16; `valid` drops after edge k+17. Throughput: one MUL/DIV per 17 gclk cycles.
- **`en`=0:** no gclk edges, so registers, counter and `valid` freeze at their current values. A stall mid-MUL/DIV resumes exactly where it stopped, with latency extended by the gated cycles. `start` is not seen while gated.

## Test plan
- Reset low for 50 ns, then ADD 100+25 → Z=0000_007D with a 1-cycle `valid`. ADD 32767+1 → Z_high=0000, Z_low=8000. SUB −32768−1 → FFFF_7FFF. SUB −250−(−50) → FFFF_FF38.
- MUL 150×120 with `en`=0 for 10 cycles mid-operation → 0000_4650, with `valid` delayed by exactly 10 cycles. MUL −150×120 → FFFF_B9B0. MUL −15000×−12000 → 0ABA_9500.
- DIV 100/3 → Z_low=0021, Z_high=0001. DIV 100/−3 → FFDF/0001. DIV −100/−3 → 0021/FFFF. DIV 15/0 → Z_low=FFFF, Z_high=000F after 1 cycle.
- CMP: 12345 vs −10000 → Z_low=0004; 500 vs 500 → 0002; −12345 vs 10000 → 0001.
- Logic on A=B=0F0F: NAND=F0F0, AND=0F0F, NOR=F0F0, OR=0F0F, XOR=0000. SHL 8 → 0F00; SHR 8 → 000F; SHR 15 → 0000.
- Rotates of 0F0F: ROL by 0/1/4/8/15 → 0F0F/1E1E/F0F0/0F0F/8787. ROR by 0/1/4/8/15 → 0F0F/8787/F0F0/0F0F/1E1E. Assert `rst` mid-MUL → outputs 0 and no `valid` pulse.
